ru_dump_reader: RTL and testbench

//  Read-side debug engine for the 32x32 register unit. It takes a range of

---
 rtl/ru_dbg_pkg.sv | 17 +
 rtl/ru_dump_reader.sv | 137 +++++++++++++
 tb/tb_ru_dump_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ru_dbg_pkg.sv
// Shared definitions for the register-unit debug logic.
// Used by the dump reader, the register unit and the core halt logic.
package ru_dbg_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dr_state_t;

endpackage

// File: rtl/ru_dump_reader.sv
// Read-side debug engine: halts the core, reads a wrapping range of registers
// through a spare read port and streams (index, value) pairs with an XOR checksum.
module ru_dump_reader
  import ru_dbg_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          DRstart,
  input  logic          DRabort,
  input  logic [AW-1:0] DRfirst,
  input  logic [AW-1:0] DRlast,
  output logic          DRhalt_req,
  input  logic          DRhalt_ack,
  output logic [AW-1:0] DRrs,
  input  logic [DW-1:0] DRrsdata,
  output logic          DRvalid,
  input  logic          DRready,
  output logic [AW-1:0] DRidx,
  output logic [DW-1:0] DRdata,
  output logic          DRbusy,
  output logic          DRdone,
  output logic [DW-1:0] DRchecksum
);

  dr_state_t     r_state;
  dr_state_t     w_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic [AW-1:0] r_count;
  logic [AW-1:0] w_count_next;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_didx;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_ck;
  logic          r_halt_req;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_load;
  logic          w_capture;
  logic          w_accept;

  // Next state plus index/count updates; abort wins over any handshake.
  always_comb begin
    w_next       = r_state;
    w_idx_next   = r_idx;
    w_count_next = r_count;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (DRstart) begin
          w_next       = HALT;
          w_load       = 1'b1;
          w_idx_next   = DRfirst;
          w_count_next = AW'(DRlast - DRfirst);
        end
      end
      HALT: begin
        if (DRabort)         w_next = IDLE;
        else if (DRhalt_ack) w_next = READ;
      end
      READ: begin
        if (DRabort) begin
          w_next = IDLE;
        end else if (DRhalt_ack) begin
          w_capture = 1'b1;
          w_next    = SEND;
        end else begin
          w_next = HALT;
        end
      end
      SEND: begin
        if (DRabort) begin
          w_next = IDLE;
        end else if (DRready) begin
          w_accept = 1'b1;
          if (r_count == '0) begin
            w_next = DONE;
          end else begin
            w_idx_next   = AW'(r_idx + AW'(1));
            w_count_next = AW'(r_count - AW'(1));
            w_next       = READ;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx      <= '0;
      r_count    <= '0;
      r_rs       <= '0;
      r_didx     <= '0;
      r_data     <= '0;
      r_ck       <= '0;
      r_halt_req <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_count    <= w_count_next;
      r_rs       <= (w_next == READ) ? w_idx_next : '0;
      r_halt_req <= (w_next == HALT) || (w_next == READ) || (w_next == SEND);
      r_valid    <= (w_next == SEND);
      r_busy     <= (w_next != IDLE);
      r_done     <= (w_next == DONE);
      if (w_capture) begin
        r_data <= DRrsdata;
        r_didx <= r_idx;
      end
      if (w_load)        r_ck <= '0;
      else if (w_accept) r_ck <= r_ck ^ r_data;
    end
  end

  assign DRhalt_req = r_halt_req;
  assign DRrs       = r_rs;
  assign DRvalid    = r_valid;
  assign DRidx      = r_didx;
  assign DRdata     = r_data;
  assign DRbusy     = r_busy;
  assign DRdone     = r_done;
  assign DRchecksum = r_ck;

endmodule

// File: tb/tb_ru_dump_reader.sv
// Scoreboard bench for ru_dump_reader: a register-file model answers the spare
// read port, expected words are queued at start and popped on every accept.
module tb_ru_dump_reader;
  import ru_dbg_pkg::*;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  logic          CLK;
  logic          RST_N;
  logic          DRstart;
  logic          DRabort;
  logic [AW-1:0] DRfirst;
  logic [AW-1:0] DRlast;
  logic          DRhalt_req;
  logic          DRhalt_ack;
  logic [AW-1:0] DRrs;
  logic [DW-1:0] DRrsdata;
  logic          DRvalid;
  logic          DRready;
  logic [AW-1:0] DRidx;
  logic [DW-1:0] DRdata;
  logic          DRbusy;
  logic          DRdone;
  logic [DW-1:0] DRchecksum;

  logic [DW-1:0] regs [NREGS];
  exp_t          q [$];
  exp_t          e;
  logic [DW-1:0] mdl_ck;
  int            n_tests;
  int            n_fail;
  int            n_done;
  int            n_acc;
  int            cyc;
  int            last_acc;
  logic          found;

  ru_dump_reader dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .DRstart    (DRstart),
    .DRabort    (DRabort),
    .DRfirst    (DRfirst),
    .DRlast     (DRlast),
    .DRhalt_req (DRhalt_req),
    .DRhalt_ack (DRhalt_ack),
    .DRrs       (DRrs),
    .DRrsdata   (DRrsdata),
    .DRvalid    (DRvalid),
    .DRready    (DRready),
    .DRidx      (DRidx),
    .DRdata     (DRdata),
    .DRbusy     (DRbusy),
    .DRdone     (DRdone),
    .DRchecksum (DRchecksum)
  );

  assign DRrsdata = regs[DRrs];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Accepts happen at the next rising edge; abort suppresses them.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (DRvalid && DRready && !DRabort) begin
        last_acc = cyc + 1;
        n_acc++;
        if (q.size() == 0) begin
          chk("extra_word", 32'(DRidx), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("word_idx", 32'(DRidx), 32'(e.idx));
          chk("word_data", DRdata, e.data);
          mdl_ck ^= e.data;
        end
      end
      if (DRdone) begin
        n_done++;
        chk("done_lat", 32'(cyc), 32'(last_acc));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dump(input logic [AW-1:0] first, input logic [AW-1:0] last);
    int n;
    logic [AW-1:0] k;
    exp_t x;
    n = int'(AW'(last - first)) + 1;
    k = first;
    for (int i = 0; i < n; i++) begin
      x.idx  = k;
      x.data = regs[k];
      q.push_back(x);
      k = AW'(k + AW'(1));
    end
    mdl_ck  = '0;
    n_acc   = 0;
    n_done  = 0;
    DRfirst = first;
    DRlast  = last;
    DRstart = 1'b1;
    tick();
    DRstart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < 300 && n_done == d0; i++) tick();
    chk(tag, 32'(n_done != d0), 32'd1);
  endtask

  task automatic wait_word(input logic [AW-1:0] idx);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (DRvalid && DRidx == idx) found = 1'b1;
    end
    chk("wait_word", 32'(found), 32'd1);
  endtask

  task automatic check_end(input string tag, input int words);
    tick();
    tick();
    chk({tag, "_q_empty"}, 32'(q.size()), 32'd0);
    chk({tag, "_nacc"}, 32'(n_acc), 32'(words));
    chk({tag, "_ck"}, DRchecksum, mdl_ck);
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
    chk({tag, "_idle"}, 32'(DRbusy), 32'd0);
  endtask

  task automatic load_random();
    regs[0] = '0;
    for (int i = 1; i < NREGS; i++) regs[i] = $urandom() | 32'h1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_done = 0; n_acc = 0; last_acc = 0;
    mdl_ck = '0;
    RST_N = 1'b0; DRstart = 1'b0; DRabort = 1'b0;
    DRfirst = '0; DRlast = '0; DRhalt_ack = 1'b1; DRready = 1'b1;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 3);
    #23;
    chk("rst_busy", 32'(DRbusy), 32'd0);
    chk("rst_valid", 32'(DRvalid), 32'd0);
    chk("rst_halt", 32'(DRhalt_req), 32'd0);
    chk("rst_ck", DRchecksum, 32'd0);
    RST_N = 1'b1;
    tick();

    // Full dump of i*3.
    start_dump(5'd0, 5'd31);
    wait_done("full_done");
    check_end("full", 32);

    // Wrapping range with latency checks.
    load_random();
    start_dump(5'd30, 5'd1);
    chk("lat_halt", 32'(DRhalt_req), 32'd1);
    chk("lat_busy", 32'(DRbusy), 32'd1);
    chk("lat_novalid", 32'(DRvalid), 32'd0);
    tick();
    chk("lat_rs", 32'(DRrs), 32'd30);
    tick();
    chk("lat_valid", 32'(DRvalid), 32'd1);
    chk("lat_rs_idle", 32'(DRrs), 32'd0);
    wait_done("wrap_done");
    check_end("wrap", 4);

    // Backpressure on word 2.
    load_random();
    start_dump(5'd4, 5'd9);
    wait_word(5'd6);
    DRready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(DRvalid), 32'd1);
      chk("bp_idx", 32'(DRidx), 32'd6);
      chk("bp_data", DRdata, regs[6]);
    end
    DRready = 1'b1;
    wait_done("bp_done");
    check_end("bp", 6);

    // Halt handshake: late ack, then ack lost during READ.
    load_random();
    DRhalt_ack = 1'b0;
    start_dump(5'd10, 5'd13);
    for (int i = 0; i < 4; i++) begin
      chk("noack_halt", 32'(DRhalt_req), 32'd1);
      chk("noack_valid", 32'(DRvalid), 32'd0);
      if (i < 3) tick();
    end
    DRhalt_ack = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (DRrs == 5'd11) found = 1'b1;
    end
    chk("read11_seen", 32'(found), 32'd1);
    DRhalt_ack = 1'b0;
    tick();
    chk("ackdrop_valid", 32'(DRvalid), 32'd0);
    chk("ackdrop_rs", 32'(DRrs), 32'd0);
    chk("ackdrop_halt", 32'(DRhalt_req), 32'd1);
    tick();
    DRhalt_ack = 1'b1;
    wait_done("ack_done");
    check_end("ack", 4);

    // Abort while word 5 is presented.
    load_random();
    start_dump(5'd0, 5'd31);
    wait_word(5'd5);
    DRabort = 1'b1;
    tick();
    DRabort = 1'b0;
    chk("abort_valid", 32'(DRvalid), 32'd0);
    chk("abort_halt", 32'(DRhalt_req), 32'd0);
    chk("abort_busy", 32'(DRbusy), 32'd0);
    chk("abort_ck", DRchecksum, mdl_ck);
    chk("abort_nacc", 32'(n_acc), 32'd5);
    q.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("abort_nodone", 32'(n_done), 32'd0);

    // Asynchronous reset mid-dump.
    start_dump(5'd0, 5'd31);
    wait_word(5'd5);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_valid", 32'(DRvalid), 32'd0);
    chk("arst_halt", 32'(DRhalt_req), 32'd0);
    chk("arst_busy", 32'(DRbusy), 32'd0);
    chk("arst_idx", 32'(DRidx), 32'd0);
    chk("arst_data", DRdata, 32'd0);
    chk("arst_ck", DRchecksum, 32'd0);
    q.delete();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("arst_nodone", 32'(n_done), 32'd0);
    chk("arst_idle", 32'(DRbusy), 32'd0);

    // Start while busy is ignored.
    load_random();
    start_dump(5'd20, 5'd24);
    tick();
    tick();
    DRfirst = 5'd2;
    DRlast  = 5'd3;
    DRstart = 1'b1;
    tick();
    DRstart = 1'b0;
    wait_done("busy_done");
    check_end("busy", 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
